// File: rtl/game_timer_pkg.sv
// -----------------------------------------------------------------------------
// game_timer_pkg
// Shared types and default durations for the game timer controller and the
// blocks that talk to it.
//   phase_t      : game phase shown on the display
//   DEF_*        : default parameter values for game_timer_ctrl
//   is_timed()   : true for phases that own a running countdown
// -----------------------------------------------------------------------------
package game_timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INTRO = 3'd1,
        ROUND = 3'd2,
        PAUSE = 3'd3,
        END   = 3'd4
    } phase_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_T_INTRO  = 50;
    localparam int DEF_T_ROUND  = 500;
    localparam int DEF_T_PAUSE  = 100;
    localparam int DEF_N_ROUNDS = 3;

    // Phases that launch the timer on entry and leave on its expiry.
    function automatic logic is_timed(input phase_t p);
        return (p == INTRO) || (p == ROUND) || (p == PAUSE);
    endfunction

endpackage

// File: rtl/game_timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_timer_ctrl_if
// Start/value/running link between the phase controller and the countdown
// timer.
//   timer_start   : one-cycle pulse, load timer_value and run
//   timer_value   : countdown length for the phase being launched
//   timer_running : high while the timer is counting
// Modports:
//   master : controller side (drives start/value, observes running)
//   slave  : timer side
// -----------------------------------------------------------------------------
interface game_timer_ctrl_if
    import game_timer_pkg::*;
#(
    parameter int width = DEF_WIDTH
) ();

    logic             timer_start;
    logic [width-1:0] timer_value;
    logic             timer_running;

    modport master (
        output timer_start,
        output timer_value,
        input  timer_running
    );

    modport slave (
        input  timer_start,
        input  timer_value,
        output timer_running
    );

endinterface

// File: rtl/game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// game_timer_ctrl
// Phase sequencer for one game: IDLE -> INTRO -> N_ROUNDS x (ROUND, PAUSE)
// -> END. Each timed phase loads and launches the external countdown timer on
// entry and leaves one edge after the timer reports it has stopped.
//
// Ports
//   clk           : clock
//   reset_n       : asynchronous active-low reset
//   game_start    : pulse, start a game (honoured in IDLE and END)
//   abort         : pulse, abandon the game and return to IDLE
//   collision     : pulse, ends the current ROUND early
//   tmr           : timer link (master side): timer_start, timer_value,
//                   timer_running
//   phase         : current phase
//   round_idx     : rounds completed in this game, 0..N_ROUNDS
//   phase_done    : one-cycle pulse when a timed phase (INTRO/ROUND/PAUSE)
//                   ends normally; abort never pulses it
//   game_over     : high while phase == END
//
// All outputs are registered. The cycle after every launch is an ARM cycle in
// which timer_running is ignored, because the timer only picks up the start
// pulse on that cycle's closing edge. Abort leaves round_idx and timer_value
// untouched; the next game start clears round_idx and reloads the timer.
// -----------------------------------------------------------------------------
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int width    = DEF_WIDTH,
    parameter int T_INTRO  = DEF_T_INTRO,
    parameter int T_ROUND  = DEF_T_ROUND,
    parameter int T_PAUSE  = DEF_T_PAUSE,
    parameter int N_ROUNDS = DEF_N_ROUNDS
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              game_start,
    input  logic                              abort,
    input  logic                              collision,
    game_timer_ctrl_if.master                 tmr,
    output phase_t                            phase,
    output logic [$clog2(N_ROUNDS + 1)-1:0]   round_idx,
    output logic                              phase_done,
    output logic                              game_over
);

    localparam int               RW         = $clog2(N_ROUNDS + 1);
    localparam logic [RW-1:0]    LAST_ROUND = RW'(N_ROUNDS);
    localparam logic [width-1:0] V_INTRO    = width'(T_INTRO);
    localparam logic [width-1:0] V_ROUND    = width'(T_ROUND);
    localparam logic [width-1:0] V_PAUSE    = width'(T_PAUSE);

    phase_t           phase_q, phase_n;
    logic             arm_q, arm_n;
    logic             start_q, start_n;
    logic [width-1:0] value_q, value_n;
    logic [RW-1:0]    round_q, round_n;
    logic             done_q, done_n;
    logic             over_q, over_n;
    logic             expired;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational block, regardless of
    // statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= IDLE;
            arm_q   <= 1'b0;
            start_q <= 1'b0;
            value_q <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            phase_q <= phase_n;
            arm_q   <= arm_n;
            start_q <= start_n;
            value_q <= value_n;
            round_q <= round_n;
            done_q  <= done_n;
            over_q  <= over_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // Priority: abort > collision > expiry > game_start. Collision and expiry
    // only matter in timed phases and game_start only in IDLE/END, so beyond
    // abort the branches are mutually exclusive in practice.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        phase_n = phase_q;
        arm_n   = 1'b0;
        start_n = 1'b0;
        value_n = value_q;
        round_n = round_q;
        done_n  = 1'b0;

        expired = is_timed(phase_q) && !arm_q && !tmr.timer_running;

        if (abort) begin
            // Timer is left running; the next launch reloads it.
            phase_n = IDLE;
        end else if (phase_q == ROUND && (collision || expired)) begin
            // Collision and expiry together still make one transition.
            phase_n = PAUSE;
            start_n = 1'b1;
            arm_n   = 1'b1;
            value_n = V_PAUSE;
            done_n  = 1'b1;
            if (round_q < LAST_ROUND) begin
                round_n = round_q + 1'b1;
            end
        end else if (expired) begin
            done_n = 1'b1;
            case (phase_q)
                INTRO: begin
                    phase_n = ROUND;
                    start_n = 1'b1;
                    arm_n   = 1'b1;
                    value_n = V_ROUND;
                end
                PAUSE: begin
                    if (round_q < LAST_ROUND) begin
                        phase_n = ROUND;
                        start_n = 1'b1;
                        arm_n   = 1'b1;
                        value_n = V_ROUND;
                    end else begin
                        phase_n = END;
                    end
                end
                default: begin
                end
            endcase
        end else if (game_start && (phase_q == IDLE || phase_q == END)) begin
            phase_n = INTRO;
            start_n = 1'b1;
            arm_n   = 1'b1;
            value_n = V_INTRO;
            round_n = '0;
        end

        over_n = (phase_n == END);
    end

    assign tmr.timer_start = start_q;
    assign tmr.timer_value = value_q;
    assign phase           = phase_q;
    assign round_idx       = round_q;
    assign phase_done      = done_q;
    assign game_over       = over_q;

endmodule
